// File: rtl/gemm_pkg.sv
// Shared definitions for the gemm sequencer: precision modes, FSM states, mode check.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gemm_pkg;

    localparam logic [2:0] SEL_NONE  = 3'b000;
    localparam logic [2:0] SEL_INT4  = 3'b001;
    localparam logic [2:0] SEL_INT2  = 3'b010;
    localparam logic [2:0] SEL_INT16 = 3'b011;
    localparam logic [2:0] SEL_INT8  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } gemm_seq_state_t;

    // Only the four datapath precisions are legal; everything else is reported as an error.
    function automatic logic is_legal_mode(input logic [2:0] mode);
        return (mode == SEL_INT4) || (mode == SEL_INT2) ||
               (mode == SEL_INT16) || (mode == SEL_INT8);
    endfunction

endpackage

// File: rtl/gemm_acc.sv
// 64-bit unsigned accumulator with clear, enable, modulo-2^64 wrap and sticky carry-out.
// Latency: addend visible in acc one cycle after en.
// Backpressure: none; adds whenever en is high.
module gemm_acc (
    input  logic        clk,
    input  logic        nrst,
    input  logic        clr,
    input  logic        en,
    input  logic [63:0] din,
    output logic [63:0] acc,
    output logic        ovf
);

    logic [63:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;
    logic        carry;
    logic [63:0] sum;

    // Next accumulator value: clear wins, otherwise add and remember any carry out of bit 63.
    always_comb begin
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        {carry, sum} = {1'b0, acc_q} + {1'b0, din};
        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (en) begin
            acc_d = sum;
            ovf_d = ovf_q | carry;
        end
    end

    // Accumulator state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/gemm_seq_ctrl.sv
// Sequencer streaming operand beats through a register stage into the gemm datapath and summing its output.
// Latency: last beat accepted at t -> result valid at t+2; degenerate command -> result next cycle.
// Backpressure: op_ready only in RUN; result held in DONE until res_ready; no new command until then.
module gemm_seq_ctrl
    import gemm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [63:0]      op_a,
    input  logic [63:0]      op_b,
    output logic [2:0]       gemm_sel,
    output logic [63:0]      gemm_a,
    output logic [63:0]      gemm_b,
    input  logic [63:0]      gemm_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic             res_err,
    output logic             res_ovf,
    output logic             busy
);

    gemm_seq_state_t  state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             stage_v_q, stage_v_d;
    logic [63:0]      gemm_a_q, gemm_a_d;
    logic [63:0]      gemm_b_q, gemm_b_d;
    logic             err_q, err_d;
    logic             acc_clr;

    // Next-state logic: command intake, operand staging and result hand-off.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        stage_v_d   = 1'b0;
        gemm_a_d    = gemm_a_q;
        gemm_b_d    = gemm_b_q;
        err_d       = err_q;
        acc_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mode_d  = cmd_mode;
                    err_d   = !is_legal_mode(cmd_mode);
                    acc_clr = 1'b1;
                    if (!is_legal_mode(cmd_mode) || (cmd_len == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        remaining_d = cmd_len;
                        state_d     = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (op_valid) begin
                    gemm_a_d    = op_a;
                    gemm_b_d    = op_b;
                    stage_v_d   = 1'b1;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            // The last staged beat accumulates during this cycle.
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset abandons any in-flight command.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            mode_q      <= SEL_NONE;
            remaining_q <= '0;
            stage_v_q   <= 1'b0;
            gemm_a_q    <= '0;
            gemm_b_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            stage_v_q   <= stage_v_d;
            gemm_a_q    <= gemm_a_d;
            gemm_b_q    <= gemm_b_d;
            err_q       <= err_d;
        end
    end

    gemm_acc u_acc (
        .clk  (clk),
        .nrst (nrst),
        .clr  (acc_clr),
        .en   (stage_v_q),
        .din  (gemm_in),
        .acc  (res_data),
        .ovf  (res_ovf)
    );

    // Outputs decode straight from registered state; the selector is zero outside RUN/DRAIN
    // so the datapath contributes nothing while idle or holding a result.
    assign cmd_ready = (state_q == ST_IDLE);
    assign op_ready  = (state_q == ST_RUN);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign gemm_sel  = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) ? mode_q : SEL_NONE;
    assign gemm_a    = gemm_a_q;
    assign gemm_b    = gemm_b_q;
    assign res_err   = err_q;

endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// Directed bench for gemm_seq_ctrl with an ideal lane-wise dot-product datapath and a result scoreboard.
// Latency: checks t+2 result timing, T+1 degenerate results and R+1 command readiness.
// Backpressure: exercises operand gaps and held results under res_ready=0.
module tb_gemm_seq_ctrl;
    import gemm_pkg::*;

    localparam int CNT_W = 16;
    localparam logic [63:0] STUB_VAL = 64'hFFFF_FFFF_FFFF_FFF0;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_mode = 3'b000;
    logic [CNT_W-1:0] cmd_len = '0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [63:0]      op_a = '0;
    logic [63:0]      op_b = '0;
    logic [2:0]       gemm_sel;
    logic [63:0]      gemm_a, gemm_b, gemm_in;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [63:0]      res_data;
    logic             res_err, res_ovf, busy;
    logic             stub_en = 1'b0;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
        logic        ovf;
    } res_t;

    res_t        exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [63:0] exp_acc;
    logic        exp_ovf;
    logic [2:0]  cur_mode;

    always #5 clk = ~clk;

    // Ideal unsigned datapath: lane-wise products summed over all lanes.
    function automatic logic [63:0] dot(input logic [63:0] a, input logic [63:0] b, input logic [2:0] sel);
        int          w;
        logic [63:0] s, x, y, m;
        s = '0;
        case (sel)
            3'b001:  w = 4;
            3'b010:  w = 2;
            3'b011:  w = 16;
            3'b100:  w = 8;
            default: w = 0;
        endcase
        if (w == 0) return 64'd0;
        m = (64'd1 << w) - 64'd1;
        for (int i = 0; i < 64 / w; i++) begin
            x = (a >> (i * w)) & m;
            y = (b >> (i * w)) & m;
            s = s + x * y;
        end
        return s;
    endfunction

    assign gemm_in = stub_en ? STUB_VAL : dot(gemm_a, gemm_b, gemm_sel);

    gemm_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_len   (cmd_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .gemm_sel  (gemm_sel),
        .gemm_a    (gemm_a),
        .gemm_b    (gemm_b),
        .gemm_in   (gemm_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_op_ready"},  64'(op_ready),  64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_res_err"},   64'(res_err),   64'd0);
        chk({tag, "_res_ovf"},   64'(res_ovf),   64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_gemm_sel"},  64'(gemm_sel),  64'd0);
        chk({tag, "_gemm_a"},    gemm_a,         64'd0);
        chk({tag, "_gemm_b"},    gemm_b,         64'd0);
        chk({tag, "_res_data"},  res_data,       64'd0);
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake (T+1).
    task automatic send_cmd(input logic [2:0] mode, input logic [CNT_W-1:0] len);
        int  n;
        res_t r;
        logic legal;
        legal     = (mode >= 3'd1) && (mode <= 3'd4);
        cmd_mode  = mode;
        cmd_len   = len;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        exp_acc   = '0;
        exp_ovf   = 1'b0;
        cur_mode  = mode;
        chk("busy_T1", 64'(busy), 64'd1);
        if (legal && len != '0) begin
            chk("op_ready_T1", 64'(op_ready), 64'd1);
            chk("sel_run",     64'(gemm_sel), 64'(mode));
        end else begin
            chk("res_valid_T1", 64'(res_valid), 64'd1);
            chk("op_ready_deg", 64'(op_ready),  64'd0);
            chk("sel_done_deg", 64'(gemm_sel),  64'd0);
            r.data = '0;
            r.err  = !legal;
            r.ovf  = 1'b0;
            exp_q.push_back(r);
        end
    endtask

    // Offers one beat, returns at the falling edge after it is accepted, then idles for gap cycles.
    task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input int gap);
        int          n;
        logic [63:0] v;
        logic        c;
        op_a = a;
        op_b = b;
        op_valid = 1'b1;
        n = 0;
        while (!op_ready && n < 50) begin @(negedge clk); n++; end
        chk("op_ready_wait", 64'(op_ready), 64'd1);
        @(negedge clk);
        op_valid = 1'b0;
        v = stub_en ? STUB_VAL : dot(a, b, cur_mode);
        {c, exp_acc} = {1'b0, exp_acc} + {1'b0, v};
        exp_ovf = exp_ovf | c;
        chk("stage_a", gemm_a, a);
        chk("stage_b", gemm_b, b);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("sel_gap",  64'(gemm_sel), 64'(cur_mode));
            chk("hold_a",   gemm_a, a);
        end
    endtask

    // Called right after the last beat (t_L+1): checks DRAIN, then result at t_L+2.
    task automatic finish_cmd();
        res_t r;
        chk("drain_no_valid", 64'(res_valid), 64'd0);
        chk("drain_op_ready", 64'(op_ready),  64'd0);
        chk("sel_drain",      64'(gemm_sel),  64'(cur_mode));
        @(negedge clk);
        chk("res_valid_tL2",  64'(res_valid), 64'd1);
        r.data = exp_acc;
        r.err  = 1'b0;
        r.ovf  = exp_ovf;
        exp_q.push_back(r);
    endtask

    task automatic get_result();
        int   n;
        res_t r;
        n = 0;
        while (!res_valid && n < 50) begin @(negedge clk); n++; end
        chk("res_valid_wait", 64'(res_valid), 64'd1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            r = exp_q.pop_front();
            chk("res_data", res_data,       r.data);
            chk("res_err",  64'(res_err),   64'(r.err));
            chk("res_ovf",  64'(res_ovf),   64'(r.ovf));
        end
        chk("sel_done",       64'(gemm_sel),  64'd0);
        chk("cmd_ready_done", 64'(cmd_ready), 64'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("cmd_ready_R1", 64'(cmd_ready), 64'd1);
        chk("res_valid_R1", 64'(res_valid), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        nrst = 1'b1;
        @(negedge clk);

        // Basic int2: all-ones operands, 3 back-to-back beats -> 3*32*9 = 864
        send_cmd(SEL_INT2, 16'd3);
        for (int i = 0; i < 3; i++) send_beat('1, '1, 0);
        finish_cmd();
        chk("int2_sum_model", exp_acc, 64'd864);
        get_result();
        chk("sel_idle", 64'(gemm_sel), 64'd0);

        // Int16 with two idle cycles between beats -> 2*(2+4+6+8) = 40
        send_cmd(SEL_INT16, 16'd2);
        send_beat({16'd1, 16'd2, 16'd3, 16'd4}, {4{16'd2}}, 2);
        send_beat({16'd1, 16'd2, 16'd3, 16'd4}, {4{16'd2}}, 0);
        finish_cmd();
        get_result();

        // Zero-length command
        send_cmd(SEL_INT4, 16'd0);
        get_result();

        // Illegal mode: beats offered must not be taken
        op_valid = 1'b1;
        send_cmd(3'b111, 16'd5);
        chk("err_no_beat", 64'(op_ready), 64'd0);
        op_valid = 1'b0;
        get_result();

        // Result backpressure with a pending command behind it
        send_cmd(SEL_INT8, 16'd1);
        send_beat(64'h0102_0304_0506_0708, 64'h0101_0101_0101_0101, 0);
        finish_cmd();
        cmd_mode  = SEL_INT4;
        cmd_len   = '0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid",     64'(res_valid), 64'd1);
            chk("bp_data",      res_data,       64'd36);
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        get_result();
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_next_accepted", 64'(res_valid), 64'd1);
        exp_q.push_back('{data: 64'd0, err: 1'b0, ovf: 1'b0});
        get_result();

        // Overflow: stubbed datapath output for two beats
        stub_en = 1'b1;
        send_cmd(SEL_INT8, 16'd2);
        send_beat(64'd1, 64'd1, 0);
        send_beat(64'd2, 64'd2, 0);
        finish_cmd();
        chk("ovf_sum_model", exp_acc, 64'hFFFF_FFFF_FFFF_FFE0);
        get_result();
        stub_en = 1'b0;

        // Reset in the middle of a 4-beat command
        send_cmd(SEL_INT8, 16'd4);
        send_beat(64'h1111, 64'h2222, 0);
        send_beat(64'h3333, 64'h4444, 0);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        chk_reset_outputs("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", 64'(res_valid), 64'd0);
        end

        // Fresh command after reset completes normally
        send_cmd(SEL_INT4, 16'd2);
        send_beat(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0023, 0);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_1111_1111_1111, 0);
        finish_cmd();
        get_result();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gemm_seq_ctrl.md
# gemm_seq_ctrl

Sequencer for the combinational `gemm` dot-product datapath. It accepts a command carrying a precision mode and a beat count, then streams that many 64-bit A/B operand beats into the datapath through a registered operand stage. It accumulates each beat's `gemm_out` into a 64-bit accumulator and returns the final sum over a valid/ready result port. It sits between the EX-stage issue logic and the `gemm` instance, and owns that instance's `bin_selector_EX`, `gemmA_in` and `gemmB_in` inputs.

## Interface
Parameters:
- `CNT_W`, default 16: width of the beat count; maximum command length is 2^CNT_W−1.

Ports (one clock, `clk`; reset `nrst` is synchronous and active-low):
- `clk`  in  1  clock, all state on rising edge
- `nrst`  in  1  synchronous active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when both high
- `cmd_mode`  in  3  001 int4x16, 010 int2x32, 011 int16x4, 100 int8x8
- `cmd_len`  in  CNT_W  number of operand beats
- `op_valid`  in  1  operand beat offered
- `op_ready`  out  1  operand beat accepted when both high
- `op_a`, `op_b`  in  64 each  operand beat
- `gemm_sel`  out  3  drives datapath `bin_selector_EX`
- `gemm_a`, `gemm_b`  out  64 each  registered operands to datapath
- `gemm_in`  in  64  datapath `gemm_out`, combinational from `gemm_a`/`gemm_b`/`gemm_sel`
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed when both high
- `res_data`  out  64  accumulated sum
- `res_err`  out  1  illegal mode; `res_data` = 0
- `res_ovf`  out  1  accumulator carried out of bit 63 at least once
- `busy`  out  1  state ≠ IDLE

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- **IDLE:** `cmd_ready`=1. On a command handshake, latch the mode and length, clear `acc`, `res_err` and `res_ovf`, then:
  - illegal mode (000, 101–111) → DONE with `res_err`=1;
  - `cmd_len`=0 → DONE with `res_data`=0;
  - otherwise → RUN with `remaining`=`cmd_len`.
- **RUN:** `op_ready`=1.
  - Each operand handshake loads `op_a`/`op_b` into `gemm_a`/`gemm_b`, sets `stage_v`=1 and decrements `remaining`.
  - A cycle without a handshake clears `stage_v`; `gemm_a`/`gemm_b` hold their values.
  - The handshake that takes `remaining` to 0 moves to DRAIN.
- **Accumulate:** every cycle with `stage_v`=1, `acc` ← `acc` + `gemm_in`. The sum is unsigned and wraps modulo 2^64. A carry out of bit 63 sets `res_ovf` (sticky for the command).
- **DRAIN:** `op_ready`=0. The final staged beat accumulates. Move to DONE.
- **DONE:** `res_valid`=1, with `res_data`=`acc` held stable. On `res_ready`, go to IDLE. `cmd_ready`=0 throughout DONE.
- **`gemm_sel`:** equals the latched mode in RUN and DRAIN, and is 000 in IDLE and DONE (datapath outputs 0).
- **Reset:** at any time, `nrst`=0 returns to IDLE and drops any in-flight command. No partial result is emitted.

## Timing
- Reset values:
  - `cmd_ready`=1;
  - `op_ready`, `res_valid`, `res_err`, `res_ovf`, `busy` = 0;
  - `gemm_sel`=000;
  - `gemm_a`, `gemm_b`, `res_data` = 0.
- Command handshake at cycle T → `busy`=1 and `op_ready`=1 at T+1.
- Zero-length or illegal command → `res_valid`=1 at T+1.
- Beat accepted at cycle t → on `gemm_a`/`gemm_b` during t+1 → included in `acc` from t+2.
- Last beat accepted at t_L → `res_valid`=1 at t_L+2.
- Throughput is one beat per cycle. `op_valid` gaps only stall the command.
- Result handshake at cycle R → `cmd_ready`=1 at R+1. This gives a minimum 2-cycle gap between commands.
- `res_data`, `res_err` and `res_ovf` are stable while `res_valid`=1 and `res_ready`=0.

## Structure
- Shared package `gemm_pkg`:
  - mode constants `SEL_INT4=3'b001`, `SEL_INT2=3'b010`, `SEL_INT16=3'b011`, `SEL_INT8=3'b100`;
  - state enum `gemm_seq_state_t`;
  - the `is_legal_mode` function.
- One sub-module, `gemm_acc`: 64-bit accumulator with clear, enable, wrap and sticky carry-out.
- The bench drives `gemm_in` from an ideal unsigned lane-wise dot-product model of `gemm_a`·`gemm_b`.

## Test plan
- **Basic int2:** mode 010, len 3, `op_a`=`op_b`=all-ones each beat, no gaps. Expect `res_data`=864 (3×32×9), `res_valid` two cycles after the last beat, `res_err`=0.
- **Int16 with gaps:** mode 011, len 2, `op_a`={16'd1,16'd2,16'd3,16'd4}, `op_b`=all 16'd2, with two idle cycles between beats. Expect `res_data`=40, and `gemm_sel`=011 only during RUN/DRAIN.
- **Degenerate commands:**
  - len 0, mode 001 → `res_valid` at T+1, `res_data`=0, no `op_ready` pulse.
  - mode 111, len 5 → `res_err`=1, `res_data`=0, no beats consumed.
- **Result backpressure:** hold `res_ready`=0 for 5 cycles with `cmd_valid`=1. Expect the result held stable and `cmd_ready`=0. The next command is accepted at R+1.
- **Overflow:** stub `gemm_in`=0xFFFF_FFFF_FFFF_FFF0 for two beats. Expect `res_data`=0xFFFF_FFFF_FFFF_FFE0 and `res_ovf`=1.
- **Reset mid-run:** assert `nrst`=0 for one cycle after 2 of 4 beats. Expect all outputs at reset values on the next cycle, no `res_valid`, and a fresh command that completes correctly.
